rv32i_if_fetch: RTL and testbench

- Instruction-fetch stage of the RV32I pipeline.
- Generates the PC, issues requests to instruction memory and buffers the returned words in an in-order fetch queue.
- Presents iw_out/pc_out to the decode stage and accepts its redirect (jump_en_in/jump_addr).
- Returns a one-cycle jump acknowledge that decode consumes as its jump_en_in.

---
 rtl/rv32i_if_fetch.sv | 184 ++++++++++++++++++
 tb/tb_rv32i_if_fetch.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_if_fetch.sv
// ---------------------------------------------------------------------------
// rv32i_if_fetch -- instruction-fetch stage of the RV32I pipeline.
//
// Generates the fetch PC, issues word requests to instruction memory under a
// credit limit of QDEPTH (outstanding requests + buffered words), tags every
// request with its PC and buffers the in-order responses in a small queue.
// Decode sees one registered word per cycle on iw_out/pc_out, or NOP_IW as a
// bubble. A redirect from decode flushes the queue, retargets the fetch PC,
// and arranges for responses already in flight to be dropped. The redirect
// is acknowledged with a one-cycle pulse.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   imem_req/imem_addr   fetch request and word-aligned address
//   imem_gnt             memory accepts the request this cycle
//   imem_rvalid/rdata    in-order read response
//   stall_in             decode cannot take a new word
//   jump_en_in/jump_addr redirect request and target
//   iw_out/pc_out        registered instruction word and its PC
//   jump_en_out          registered redirect acknowledge pulse
//
// Optional build macro FETCH_STATS_EN adds saturating counters
// stat_fetched, stat_redirects and stat_dropped.
// ---------------------------------------------------------------------------
module rv32i_if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2,
  parameter logic [31:0] NOP_IW   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_in,
  input  logic        jump_en_in,
  input  logic [31:0] jump_addr,
  output logic [31:0] iw_out,
  output logic [31:0] pc_out,
  output logic        jump_en_out
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_redirects,
  output logic [31:0] stat_dropped
`endif
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam logic [CW:0] CREDITS = (CW + 1)'(QDEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] q_cnt;
  logic [PW-1:0] q_rd, q_wr;
  logic [PW-1:0] tag_rd, tag_wr;
  logic [31:0]   q_iw   [QDEPTH];
  logic [31:0]   q_pc   [QDEPTH];
  logic [31:0]   tag_pc [QDEPTH];

  logic          grant, resp, drop, push, pop;
  logic [CW-1:0] outstanding_nxt, discard_nxt;

  // Only the low address bits of the redirect target are ignored.
  logic unused_jump_lsbs;
  assign unused_jump_lsbs = ^jump_addr[1:0];

  // The request depends only on registered state, so it cannot glitch on
  // inputs and stays stable while waiting for a grant.
  always_comb begin
    imem_req  = (state != IDLE) && (({1'b0, outstanding} + {1'b0, q_cnt}) < CREDITS);
    imem_addr = fetch_pc;
  end

  always_comb begin
    grant = imem_req && imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    resp  = imem_rvalid && (outstanding != '0);
    // Stale responses, and any response landing in a redirect cycle, are lost.
    drop  = resp && (jump_en_in || (discard != '0));
    push  = resp && !drop;
    pop   = !jump_en_in && !stall_in && (q_cnt != '0);
    outstanding_nxt = outstanding + CW'(grant) - CW'(resp);
    if (jump_en_in)
      discard_nxt = outstanding_nxt;
    else if (resp && (discard != '0))
      discard_nxt = discard - CW'(1);
    else
      discard_nxt = discard;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      q_cnt       <= '0;
      q_rd        <= '0;
      q_wr        <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      iw_out      <= NOP_IW;
      pc_out      <= '0;
      jump_en_out <= 1'b0;
    end else begin
      case (state)
        IDLE:    state <= RUN;
        default: state <= (discard_nxt != '0) ? DRAIN : RUN;
      endcase

      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      jump_en_out <= jump_en_in;

      // Tags are consumed on every response, dropped or not, so the tag FIFO
      // survives redirects untouched and stays aligned with the memory.
      if (grant) tag_wr <= tag_wr + PW'(1);
      if (resp)  tag_rd <= tag_rd + PW'(1);

      if (jump_en_in)
        fetch_pc <= {jump_addr[31:2], 2'b00};
      else if (grant)
        fetch_pc <= fetch_pc + 32'd4;

      if (jump_en_in) begin
        q_cnt  <= '0;
        q_rd   <= '0;
        q_wr   <= '0;
        iw_out <= NOP_IW;
      end else begin
        if (push) q_wr <= q_wr + PW'(1);
        if (pop)  q_rd <= q_rd + PW'(1);
        q_cnt <= q_cnt + CW'(push) - CW'(pop);
        if (!stall_in) begin
          if (pop) begin
            iw_out <= q_iw[q_rd];
            pc_out <= q_pc[q_rd];
          end else begin
            iw_out <= NOP_IW;
          end
        end
      end
    end
  end

  // NOTE: the storage arrays have no reset; which entries are valid is known
  // only from the pointers and counts above, which are reset.
  always_ff @(posedge clk) begin
    if (grant) tag_pc[tag_wr] <= fetch_pc;
    if (push) begin
      q_iw[q_wr] <= imem_rdata;
      q_pc[q_wr] <= tag_pc[tag_rd];
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetched   <= '0;
      stat_redirects <= '0;
      stat_dropped   <= '0;
    end else begin
      if (pop && (stat_fetched != '1))          stat_fetched   <= stat_fetched + 32'd1;
      if (jump_en_in && (stat_redirects != '1)) stat_redirects <= stat_redirects + 32'd1;
      if (drop && (stat_dropped != '1))         stat_dropped   <= stat_dropped + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  rvalid_needs_request: assert property (@(posedge clk) disable iff (reset)
    !(imem_rvalid && (outstanding == '0)))
    else $error("rv32i_if_fetch: imem_rvalid with no outstanding request");
`endif

endmodule

// File: tb/tb_rv32i_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_rv32i_if_fetch -- self-checking bench for rv32i_if_fetch.
// A behavioural memory answers granted requests in order after a random
// latency with data = address ^ KEY. The reference model tracks the expected
// program stream: granted addresses run sequentially from the last redirect
// target, delivered PCs run sequentially from the last redirect target, and
// each delivered word must equal its PC ^ KEY.
// ---------------------------------------------------------------------------
module tb_rv32i_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 2;
  localparam logic [31:0] NOP_IW   = 32'h0000_0013;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_in;
  logic        jump_en_in;
  logic [31:0] jump_addr;
  logic [31:0] iw_out;
  logic [31:0] pc_out;
  logic        jump_en_out;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_redirects, stat_dropped;
`endif

  rv32i_if_fetch #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH), .NOP_IW(NOP_IW)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall_in    (stall_in),
    .jump_en_in  (jump_en_in),
    .jump_addr   (jump_addr),
    .iw_out      (iw_out),
    .pc_out      (pc_out),
    .jump_en_out (jump_en_out)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_redirects (stat_redirects),
    .stat_dropped   (stat_dropped)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  // Memory model
  req_t pend[$];
  int   cyc;
  int   gnt_pct, lat_min, lat_max;
  bit   gnt_low;

  // Reference model
  logic [31:0] exp_fetch, exp_next_pc, prev_iw, prev_pc, held_addr;
  bit          hold_pending;
  int          disc, n_delivered, n_redirects, n_dropped, n_grants;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_mem();
    imem_gnt = gnt_low ? 1'b0 : ($urandom_range(99) < gnt_pct);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend[0].addr ^ KEY;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom();
    end
  endtask

  task automatic check_stats();
`ifdef FETCH_STATS_EN
    check("stat_fetched", stat_fetched, n_delivered);
    check("stat_redirects", stat_redirects, n_redirects);
    check("stat_dropped", stat_dropped, n_dropped);
`endif
  endtask

  // Enter and leave reset; the memory is reset together with the block.
  task automatic do_reset();
    reset = 1'b1;  stall_in = 1'b0; jump_en_in = 1'b0; jump_addr = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_iw", iw_out, NOP_IW);
    check("rst_pc", pc_out, 32'h0);
    check("rst_jack", jump_en_out, 1'b0);
    pend.delete();
    cyc = 0; disc = 0; hold_pending = 0; held_addr = '0;
    exp_fetch = RESET_PC; exp_next_pc = RESET_PC;
    prev_iw = NOP_IW; prev_pc = '0;
    n_delivered = 0; n_redirects = 0; n_dropped = 0; n_grants = 0;
    check_stats();
    reset = 1'b0;
    #1;
    check("idle_no_req", imem_req, 1'b0);
    drive_mem();
  endtask

  // One clock cycle: sample the request side before the edge, check the
  // decode side after it, then drive the memory for the next cycle.
  task automatic tick();
    logic        s_req, s_gnt, s_rv, s_jump, s_stall;
    logic [31:0] s_addr, s_jaddr;
    req_t        r;
    #1;
    s_req = imem_req;  s_gnt = imem_gnt; s_rv = imem_rvalid;
    s_jump = jump_en_in; s_stall = stall_in;
    s_addr = imem_addr; s_jaddr = jump_addr;
    if (hold_pending) begin
      check("req_hold", s_req, 1'b1);
      check("addr_hold", s_addr, held_addr);
    end
    if (s_rv) begin
      void'(pend.pop_front());
      if (s_jump || disc > 0) n_dropped++;
      if (disc > 0) disc--;
    end
    if (s_req && s_gnt) begin
      check("grant_addr", s_addr, exp_fetch);
      r.addr = s_addr;
      r.due  = cyc + int'($urandom_range(lat_max, lat_min));
      pend.push_back(r);
      exp_fetch += 32'd4;
      n_grants++;
    end
    check("credit", (pend.size() <= QDEPTH), 1'b1);
    if (s_jump) begin
      disc = pend.size();
      exp_fetch = {s_jaddr[31:2], 2'b00};
      n_redirects++;
    end
    hold_pending = s_req && !s_gnt && !s_jump;
    held_addr    = s_addr;

    @(posedge clk);
    #1;
    cyc++;
    check("jump_ack", jump_en_out, s_jump);
    if (s_jump) begin
      check("redir_bubble", iw_out, NOP_IW);
      exp_next_pc = {s_jaddr[31:2], 2'b00};
    end else if (s_stall) begin
      check("stall_iw", iw_out, prev_iw);
      check("stall_pc", pc_out, prev_pc);
    end else if (iw_out !== NOP_IW) begin
      check("deliver_pc", pc_out, exp_next_pc);
      check("deliver_iw", iw_out, exp_next_pc ^ KEY);
      exp_next_pc += 32'd4;
      n_delivered++;
    end else begin
      check("bubble_pc", pc_out, prev_pc);
    end
    check_stats();

    @(negedge clk);
    prev_iw = iw_out;
    prev_pc = pc_out;
    drive_mem();
  endtask

  task automatic wait_delivered(input int target, input int budget);
    for (int i = 0; i < budget && n_delivered < target; i++) tick();
    check("deliver_timeout", (n_delivered >= target), 1'b1);
  endtask

  initial begin
    int d0;
    logic [31:0] a0;
    gnt_pct = 100; lat_min = 1; lat_max = 1; gnt_low = 0;
    reset = 1'b1; stall_in = 1'b0; jump_en_in = 1'b0; jump_addr = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // Zero-wait memory: bubbles first, then the sequential stream.
    do_reset();
    repeat (2) tick();
    check("first_bubble", iw_out, NOP_IW);
    repeat (10) tick();
    check("zw_progress", (n_delivered >= 4), 1'b1);

    // Stall after two words: credit bound holds, stream resumes at 0x8, 0xC.
    do_reset();
    wait_delivered(2, 40);
    stall_in = 1'b1;
    repeat (5) tick();
    check("stall_credit", ((n_grants - n_delivered) <= QDEPTH), 1'b1);
    stall_in = 1'b0;
    wait_delivered(4, 40);
    check("resume_pc", pc_out, 32'h0000_000C);

    // Redirect with two responses in flight at latency 3.
    lat_min = 3; lat_max = 3;
    do_reset();
    for (int i = 0; i < 20 && pend.size() < 2; i++) tick();
    check("two_in_flight", pend.size(), 2);
    d0 = n_delivered;
    jump_en_in = 1'b1; jump_addr = 32'h0000_0103;
    tick();
    jump_en_in = 1'b0;
    check("redir_addr", imem_addr, 32'h0000_0100);
    tick();
    wait_delivered(d0 + 1, 40);
    check("redir_first_pc", pc_out, 32'h0000_0100);
    check("redir_first_iw", iw_out, 32'h0000_0100 ^ KEY);

    // Redirect together with stall.
    lat_min = 1; lat_max = 1;
    repeat (6) tick();
    stall_in = 1'b1; jump_en_in = 1'b1; jump_addr = 32'h0000_0200;
    tick();
    jump_en_in = 1'b0;
    tick();
    check("stall_redir_iw", iw_out, NOP_IW);
    stall_in = 1'b0;
    d0 = n_delivered;
    wait_delivered(d0 + 1, 40);
    check("stall_redir_pc", pc_out, 32'h0000_0200);

    // Grant withheld: request holds, then a redirect retargets it.
    gnt_low = 1; imem_gnt = 1'b0;
    for (int i = 0; i < 20 && !imem_req; i++) tick();
    check("req_pending", imem_req, 1'b1);
    a0 = imem_addr;
    repeat (4) tick();
    check("req_held", imem_req, 1'b1);
    check("addr_held", imem_addr, a0);
    jump_en_in = 1'b1; jump_addr = 32'h0000_0302;
    tick();
    jump_en_in = 1'b0;
    check("retarget_addr", imem_addr, 32'h0000_0300);
    gnt_low = 0; imem_gnt = 1'b1;
    d0 = n_delivered;
    wait_delivered(d0 + 1, 40);
    check("retarget_pc", pc_out, 32'h0000_0300);

    // PC wraps at the top of the address space.
    jump_en_in = 1'b1; jump_addr = 32'hFFFF_FFF9;
    tick();
    jump_en_in = 1'b0;
    d0 = n_delivered;
    wait_delivered(d0 + 3, 60);
    check("wrap_pc", pc_out, 32'h0000_0000);

    // Randomized traffic.
    gnt_pct = 70; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      stall_in   = ($urandom_range(99) < 30);
      jump_en_in = ($urandom_range(99) < 6);
      jump_addr  = $urandom();
      tick();
    end
    stall_in = 1'b0; jump_en_in = 1'b0;
    d0 = n_delivered;
    repeat (40) tick();
    check("random_progress", ((n_delivered - d0) >= 5), 1'b1);

    // Reset in the middle of traffic.
    for (int i = 0; i < 7; i++) begin
      stall_in = ($urandom_range(99) < 30);
      tick();
    end
    do_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 2;
    wait_delivered(3, 40);
    check("post_reset_pc", pc_out, 32'h0000_0008);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
